axi_lite_master: RTL and testbench

AXI-lite initiator that turns one simple core-side memory request (read or write) into a single AXI-lite transaction. It is the master-side counterpart to the team's AXI-lite DRAM slave. It sits between the IFU/LSU and the memory interconnect. At most one transaction is outstanding; the response (read data plus error flag) is returned on a separate valid/ready channel.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_master.sv | 139 +++++++++++++
 tb/tb_axi_lite_master.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Types and constants shared by the AXI-lite master and its users.
// Holds the transaction state enum and the AXI response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// Converts one core-side read/write request into a single AXI-lite transaction.
// One transaction outstanding; the result is returned on a valid/ready channel.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [STRB_WIDTH-1:0] wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                    err_reg, err_next;
  logic                    aw_done_reg, aw_done_next;
  logic                    w_done_reg, w_done_next;
  logic                    req_fire;

  assign req_fire = (state_reg == IDLE) && req_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      if (req_fire) begin
        addr_reg  <= req_addr_i;
        wdata_reg <= req_wdata_i;
        wstrb_reg <= req_wstrb_i;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) state_next = req_we_i ? WRITE : RADDR;
      end
      RADDR: begin
        if (arready_i) state_next = RDATA;
      end
      RDATA: begin
        if (rvalid_i) begin
          rdata_next = rdata_i;
          err_next   = (rresp_i != RESP_OKAY);
          state_next = RSP;
        end
      end
      WRITE: begin
        // A ready seen after its own handshake is harmless: the flag is already set.
        aw_done_next = aw_done_reg | awready_i;
        w_done_next  = w_done_reg | wready_i;
        if (aw_done_next && w_done_next) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WRESP;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          rdata_next = '0;
          err_next   = (bresp_i != RESP_OKAY);
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every handshake output is a pure decode of registered state.
  always_comb begin
    req_ready_o = (state_reg == IDLE);
    arvalid_o   = (state_reg == RADDR);
    rready_o    = (state_reg == RDATA);
    awvalid_o   = (state_reg == WRITE) && !aw_done_reg;
    wvalid_o    = (state_reg == WRITE) && !w_done_reg;
    bready_o    = (state_reg == WRESP);
    rsp_valid_o = (state_reg == RSP);
  end

  assign araddr_o    = addr_reg;
  assign awaddr_o    = addr_reg;
  assign wdata_o     = wdata_reg;
  assign wstrb_o     = wstrb_reg;
  assign rsp_rdata_o = rdata_reg;
  assign rsp_err_o   = err_reg;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: stub DRAM slave with programmable/random latency,
// byte-level shadow memory model, vector table and directed corner sequences.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  axi_lite_master dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- stub slave (decides at negedge for the next rising edge)
  logic [31:0] mem [256] = '{default: 32'h0};
  int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;  // <0 means random 0..15
  logic [1:0]  cfg_rresp = RESP_OKAY, cfg_bresp = RESP_OKAY;

  function automatic int lat(input int c);
    return (c < 0) ? int'($urandom_range(15, 0)) : c;
  endfunction

  initial begin
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit ar_arm, r_arm, aw_arm, w_arm, b_arm;
    bit ar_fq, r_fq, aw_fq, w_fq, b_fq, rd_busy, aw_got, w_got;
    logic [7:0]  rd_idx, wr_idx;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    rd_idx = '0; wr_idx = '0; w_data_s = '0; w_strb_s = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_arm = 0; r_arm = 0; aw_arm = 0; w_arm = 0; b_arm = 0;
        ar_fq = 0; r_fq = 0; aw_fq = 0; w_fq = 0; b_fq = 0;
        rd_busy = 0; aw_got = 0; w_got = 0;
      end else begin
        if (ar_fq) begin
          arready = 0; ar_fq = 0; ar_arm = 0; rd_busy = 1;
        end else if (arvalid && !rd_busy) begin
          if (!ar_arm) begin ar_wait = lat(cfg_ar); ar_arm = 1; end
          if (ar_wait == 0) begin arready = 1; ar_fq = 1; rd_idx = araddr[9:2]; end
          else ar_wait--;
        end
        if (r_fq) begin
          rvalid = 0; r_fq = 0; r_arm = 0; rd_busy = 0;
        end else if (rd_busy && !rvalid) begin
          if (!r_arm) begin r_wait = lat(cfg_r); r_arm = 1; end
          if (r_wait == 0) begin rvalid = 1; rdata = mem[rd_idx]; rresp = cfg_rresp; end
          else r_wait--;
        end
        if (rvalid && rready) r_fq = 1;

        if (aw_fq) begin
          awready = 0; aw_fq = 0; aw_arm = 0; aw_got = 1;
        end else if (awvalid && !aw_got) begin
          if (!aw_arm) begin aw_wait = lat(cfg_aw); aw_arm = 1; end
          if (aw_wait == 0) begin awready = 1; aw_fq = 1; wr_idx = awaddr[9:2]; end
          else aw_wait--;
        end
        if (w_fq) begin
          wready = 0; w_fq = 0; w_arm = 0; w_got = 1;
        end else if (wvalid && !w_got) begin
          if (!w_arm) begin w_wait = lat(cfg_w); w_arm = 1; end
          if (w_wait == 0) begin wready = 1; w_fq = 1; w_data_s = wdata; w_strb_s = wstrb; end
          else w_wait--;
        end
        if (b_fq) begin
          bvalid = 0; b_fq = 0; b_arm = 0;
        end else if (aw_got && w_got && !bvalid) begin
          if (!b_arm) begin b_wait = lat(cfg_b); b_arm = 1; end
          if (b_wait == 0) begin
            if (cfg_bresp == RESP_OKAY)
              for (int i = 0; i < 4; i++)
                if (w_strb_s[i]) mem[wr_idx][8*i +: 8] = w_data_s[8*i +: 8];
            bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0;
          end else b_wait--;
        end
        if (bvalid && bready) b_fq = 1;
      end
    end
  end

  // ---------------- reference model: byte-addressed memory
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v = '0;
    logic [31:0] base = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++)
      if (shadow.exists(base + i)) v[8*i +: 8] = shadow[base + i];
    return v;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] base = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++)
      if (s[i]) shadow[base + i] = d[8*i +: 8];
  endfunction

  // ---------------- master-side drivers
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL req_accept_timeout: actual=no_ready required=ready");
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int l);
    l = 0;
    rsp_ready = 1;
    do begin @(negedge clk); l++; end while (!rsp_valid && l < 200);
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: actual=%0d cycles required=rsp_valid", l);
    end
    d = rsp_rdata; e = rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic er, output int l);
    logic [31:0] exp_d;
    logic        exp_e;
    if (we) begin
      exp_d = '0; exp_e = (cfg_bresp != RESP_OKAY);
    end else begin
      exp_d = model_read(a); exp_e = (cfg_rresp != RESP_OKAY);
    end
    start_req(we, a, d, s);
    wait_rsp(rd, er, l);
    $display("txn %s addr=%h wdata=%h strb=%h -> rdata=%h err=%0d lat=%0d",
             we ? "WR" : "RD", a, d, s, rd, er, l);
    check(we ? "model_wr_rdata" : "model_rd_rdata", rd, exp_d);
    check("model_err", {31'b0, er}, {31'b0, exp_e});
    if (we && !exp_e) model_write(a, d, s);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl [9];
    logic [31:0] rd;
    logic        er;
    int          l, n;

    tbl[0] = '{1'b1, 32'h100, 32'h11223344, 4'hF, RESP_OKAY,   32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h100, 32'h0,        4'h0, RESP_OKAY,   32'h11223344, 1'b0};
    tbl[2] = '{1'b1, 32'h100, 32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h0,        1'b0};
    tbl[3] = '{1'b0, 32'h100, 32'h0,        4'h0, RESP_OKAY,   32'h11BB33DD, 1'b0};
    tbl[4] = '{1'b0, 32'h100, 32'h0,        4'h0, RESP_SLVERR, 32'h11BB33DD, 1'b1};
    tbl[5] = '{1'b1, 32'h104, 32'hCAFEF00D, 4'hF, RESP_DECERR, 32'h0,        1'b1};
    tbl[6] = '{1'b0, 32'h104, 32'h0,        4'h0, RESP_OKAY,   32'h0,        1'b0};
    tbl[7] = '{1'b1, 32'h108, 32'hFF000000, 4'h8, RESP_EXOKAY, 32'h0,        1'b1};
    tbl[8] = '{1'b0, 32'h108, 32'h0,        4'h0, RESP_OKAY,   32'h0,        1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_arvalid",   {31'b0, arvalid}, 32'd0);
    check("rst_awvalid",   {31'b0, awvalid}, 32'd0);
    check("rst_wvalid",    {31'b0, wvalid}, 32'd0);
    check("rst_rready",    {31'b0, rready}, 32'd0);
    check("rst_bready",    {31'b0, bready}, 32'd0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata",  wdata, 32'h0);
    check("rst_wstrb",  {28'b0, wstrb}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1;

    // zero-wait write then zero-wait read with cycle-level checks
    txn(1'b1, 32'h80000020, 32'hDEADBEEF, 4'hF, rd, er, l);
    check("wr_zero_wait_latency", l, 32'd3);
    start_req(1'b0, 32'h80000020, 32'h0, 4'h0);
    @(negedge clk);
    check("rd_c1_arvalid", {31'b0, arvalid}, 32'd1);
    check("rd_c1_araddr", araddr, 32'h80000020);
    @(negedge clk);
    check("rd_c2_rready", {31'b0, rready}, 32'd1);
    @(negedge clk);
    check("rd_c3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_c3_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_c3_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    check("rd_b2b_req_ready", {31'b0, req_ready}, 32'd1);

    // W completes before AW
    cfg_aw = 3;
    start_req(1'b1, 32'h80000010, 32'h12345678, 4'hF);
    @(negedge clk);
    check("wa_c1_awvalid", {31'b0, awvalid}, 32'd1);
    check("wa_c1_wvalid",  {31'b0, wvalid}, 32'd1);
    check("wa_c1_awaddr", awaddr, 32'h80000010);
    check("wa_c1_wdata",  wdata, 32'h12345678);
    @(negedge clk);
    check("wa_c2_wvalid",  {31'b0, wvalid}, 32'd0);
    check("wa_c2_awvalid", {31'b0, awvalid}, 32'd1);
    @(negedge clk);
    check("wa_c3_awvalid", {31'b0, awvalid}, 32'd1);
    @(negedge clk);
    check("wa_c4_awvalid", {31'b0, awvalid}, 32'd1);
    check("wa_c4_awaddr", awaddr, 32'h80000010);
    @(negedge clk);
    check("wa_c5_bready",  {31'b0, bready}, 32'd1);
    check("wa_c5_awvalid", {31'b0, awvalid}, 32'd0);
    @(negedge clk);
    check("wa_c6_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("wa_c6_rdata", rsp_rdata, 32'h0);
    model_write(32'h80000010, 32'h12345678, 4'hF);
    cfg_aw = 0;
    txn(1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, l);
    check("wa_readback", rd, 32'h12345678);

    // simultaneous AW/W with partial strobe
    txn(1'b1, 32'h80000030, 32'hAABBCCDD, 4'hF, rd, er, l);
    start_req(1'b1, 32'h80000030, 32'h00001111, 4'h3);
    @(negedge clk);
    check("sim_c1_both_valid", {30'b0, awvalid, wvalid}, 32'd3);
    @(negedge clk);
    check("sim_c2_bready", {31'b0, bready}, 32'd1);
    check("sim_c2_valids_low", {30'b0, awvalid, wvalid}, 32'd0);
    @(negedge clk);
    check("sim_c3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    model_write(32'h80000030, 32'h00001111, 4'h3);
    txn(1'b0, 32'h80000030, 32'h0, 4'h0, rd, er, l);
    check("sim_readback", rd, 32'hAABB1111);

    // vector table, including error responses
    for (int i = 0; i < 9; i++) begin
      cfg_rresp = tbl[i].resp;
      cfg_bresp = tbl[i].resp;
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, er, l);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
    end
    cfg_rresp = RESP_OKAY;
    cfg_bresp = RESP_OKAY;

    // response backpressure
    rsp_ready = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h80000030;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rsp_valid", c), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d_rdata", c), rsp_rdata, 32'hAABB1111);
      check($sformatf("bp%0d_err", c), {31'b0, rsp_err}, 32'd0);
      check($sformatf("bp%0d_req_ready", c), {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1;
    $display("txn RD addr=80000030 held 5 cycles under backpressure");

    // random traffic with random slave latency on every channel
    cfg_ar = -1; cfg_r = -1; cfg_aw = -1; cfg_w = -1; cfg_b = -1;
    for (int k = 0; k < 100; k++) begin
      logic        we_r;
      logic [31:0] a_r, d_r;
      logic [3:0]  s_r;
      we_r = 1'($urandom_range(1, 0));
      a_r  = 32'h80000000 + 32'($urandom_range(15, 0)) * 4;
      d_r  = $urandom;
      s_r  = 4'($urandom_range(15, 0));
      txn(we_r, a_r, d_r, s_r, rd, er, l);
    end

    // reset while waiting in RDATA
    cfg_ar = 0; cfg_r = 8; cfg_aw = 0; cfg_w = 0; cfg_b = 0;
    start_req(1'b0, 32'h80000030, 32'h0, 4'h0);
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    check("rr_reached_rdata", {31'b0, rready}, 32'd1);
    rst_n = 0;
    #1;
    check("rr_valids_low", {26'b0, arvalid, awvalid, wvalid, rready, bready, rsp_valid}, 32'd0);
    check("rr_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    cfg_r = 0;
    txn(1'b0, 32'h80000030, 32'h0, 4'h0, rd, er, l);
    check("rr_post_reset_latency", l, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=expired required=finish");
    $fatal(1, "timeout");
  end

endmodule
